error_weight_scheduler: RTL and testbench

// Sequences the weight inputs of the ErrorCombiner. The ADPLL starts with acquisition weights
// (coarse detectors) and moves to tracking weights (fine detectors) once the combined error stays

---
 rtl/error_weight_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_error_weight_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/error_weight_scheduler.sv
// error_weight_scheduler
// Schedules the four ErrorCombiner weights for the ADPLL. The loop starts on the
// acquisition weight set. Once the combined error has stayed small for long enough,
// the weights ramp one LSB at a time toward the tracking set, so the loop never sees
// a step. After a run of large errors in TRACK (loss of lock), the scheduler loads
// the acquisition weights again in one step.
//
// Ports
//   clk_i            system clock
//   reset_n_i        asynchronous active-low reset
//   enable_i         1 = run scheduling, 0 = force IDLE
//   sample_valid_i   strobe: error_comb_i holds a new sample
//   error_comb_i     signed combined error from ErrorCombiner
//   cfg_load_i       rising edge loads the acq/trk shadow registers
//   acq_weights_i    acquisition weights, weight 0 in the LSBs
//   trk_weights_i    tracking weights, weight 0 in the LSBs
//   cfg_ack_o        one-cycle acknowledge of a cfg_load_i rising edge
//   weight_0_o..3_o  signed weights to ErrorCombiner
//   combiner_reset_o ErrorCombiner reset (active high)
//   locked_o         high only in TRACK
//   state_o          current state encoding
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE  00 | disabled: weights 0, combiner held in reset
// ACQUIRE 01 | acquisition weights, counting consecutive good samples
// RAMP  10 | stepping weights toward the latched tracking target
// TRACK 11 | tracking weights, locked, counting consecutive bad samples
module error_weight_scheduler #(
    parameter int WEIGHT_W      = 4,
    parameter int ERR_W         = 8,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4,
    parameter int RAMP_INTERVAL = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  enable_i,
    input  logic                  sample_valid_i,
    input  logic [ERR_W-1:0]      error_comb_i,
    input  logic                  cfg_load_i,
    input  logic [4*WEIGHT_W-1:0] acq_weights_i,
    input  logic [4*WEIGHT_W-1:0] trk_weights_i,
    output logic                  cfg_ack_o,
    output logic [WEIGHT_W-1:0]   weight_0_o,
    output logic [WEIGHT_W-1:0]   weight_1_o,
    output logic [WEIGHT_W-1:0]   weight_2_o,
    output logic [WEIGHT_W-1:0]   weight_3_o,
    output logic                  combiner_reset_o,
    output logic                  locked_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_RAMP    = 2'b10,
        ST_TRACK   = 2'b11
    } state_t;

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int RAMP_W = $clog2(RAMP_INTERVAL + 1);

    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(UNLOCK_COUNT);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_INTERVAL - 1);
    localparam logic [ERR_W-1:0]  ERR_MIN   = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0]  ERR_MAX   = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0]  THRESH    = ERR_W'(LOCK_THRESH);

    state_t                  state_q, state_d;
    logic [4*WEIGHT_W-1:0]   weights_q, weights_d;
    logic [4*WEIGHT_W-1:0]   acq_shadow_q, acq_shadow_d;
    logic [4*WEIGHT_W-1:0]   trk_shadow_q, trk_shadow_d;
    logic [4*WEIGHT_W-1:0]   target_q, target_d;
    logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]        bad_cnt_q, bad_cnt_d;
    logic [RAMP_W-1:0]       ramp_cnt_q, ramp_cnt_d;
    logic                    cfg_load_prev_q, cfg_load_prev_d;
    logic                    cfg_ack_q, cfg_ack_d;
    logic                    comb_reset_q, comb_reset_d;
    logic                    locked_q, locked_d;

    logic                    cfg_edge;
    logic [ERR_W-1:0]        err_abs;
    logic                    sample_good;
    logic [GOOD_W-1:0]       good_inc;
    logic [BAD_W-1:0]        bad_inc;

    // One LSB toward the target. The operands are sign-extended by one bit so that
    // the +/-1 cannot wrap. The result is always between cur and tgt, so it fits back
    // into WEIGHT_W bits.
    function automatic logic [WEIGHT_W-1:0] step_toward(input logic [WEIGHT_W-1:0] cur,
                                                        input logic [WEIGHT_W-1:0] tgt);
        logic signed [WEIGHT_W:0] cur_x;
        logic signed [WEIGHT_W:0] tgt_x;
        logic signed [WEIGHT_W:0] nxt_x;
        cur_x = {cur[WEIGHT_W-1], cur};
        tgt_x = {tgt[WEIGHT_W-1], tgt};
        if (cur_x < tgt_x) begin
            nxt_x = cur_x + (WEIGHT_W+1)'(1);
        end else if (cur_x > tgt_x) begin
            nxt_x = cur_x - (WEIGHT_W+1)'(1);
        end else begin
            nxt_x = cur_x;
        end
        return nxt_x[WEIGHT_W-1:0];
    endfunction

    always_comb begin
        // The most negative error has no positive counterpart, so its magnitude is clamped.
        if (error_comb_i[ERR_W-1]) begin
            err_abs = (error_comb_i == ERR_MIN) ? ERR_MAX : (~error_comb_i + 1'b1);
        end else begin
            err_abs = error_comb_i;
        end
        sample_good = (err_abs <= THRESH);
        good_inc    = (good_cnt_q == GOOD_MAX) ? GOOD_MAX : good_cnt_q + 1'b1;
        bad_inc     = (bad_cnt_q == BAD_MAX) ? BAD_MAX : bad_cnt_q + 1'b1;
    end

    always_comb begin
        state_d         = state_q;
        weights_d       = weights_q;
        acq_shadow_d    = acq_shadow_q;
        trk_shadow_d    = trk_shadow_q;
        target_d        = target_q;
        good_cnt_d      = good_cnt_q;
        bad_cnt_d       = bad_cnt_q;
        ramp_cnt_d      = ramp_cnt_q;
        comb_reset_d    = comb_reset_q;
        locked_d        = locked_q;

        // The config path runs in every state, including while disabled.
        cfg_edge        = cfg_load_i & ~cfg_load_prev_q;
        cfg_load_prev_d = cfg_load_i;
        cfg_ack_d       = cfg_edge;
        if (cfg_edge) begin
            acq_shadow_d = acq_weights_i;
            trk_shadow_d = trk_weights_i;
        end

        if (!enable_i) begin
            state_d      = ST_IDLE;
            weights_d    = '0;
            good_cnt_d   = '0;
            bad_cnt_d    = '0;
            ramp_cnt_d   = '0;
            comb_reset_d = 1'b1;
            locked_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_ACQUIRE;
                    weights_d    = acq_shadow_q;
                    comb_reset_d = 1'b0;
                    locked_d     = 1'b0;
                    good_cnt_d   = '0;
                    bad_cnt_d    = '0;
                    ramp_cnt_d   = '0;
                end
                ST_ACQUIRE: begin
                    if (sample_valid_i) begin
                        if (!sample_good) begin
                            good_cnt_d = '0;
                        end else if (good_inc == GOOD_MAX) begin
                            // The ramp target is latched here, so a later config
                            // load cannot change a ramp that is in progress.
                            state_d    = ST_RAMP;
                            target_d   = trk_shadow_q;
                            ramp_cnt_d = '0;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end else begin
                            good_cnt_d = good_inc;
                        end
                    end
                end
                ST_RAMP: begin
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                    if (weights_q == target_q) begin
                        state_d    = ST_TRACK;
                        locked_d   = 1'b1;
                        ramp_cnt_d = '0;
                    end else if (ramp_cnt_q == RAMP_LAST) begin
                        for (int i = 0; i < 4; i++) begin
                            weights_d[i*WEIGHT_W +: WEIGHT_W] =
                                step_toward(weights_q[i*WEIGHT_W +: WEIGHT_W],
                                            target_q[i*WEIGHT_W +: WEIGHT_W]);
                        end
                        ramp_cnt_d = '0;
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (sample_valid_i) begin
                        if (sample_good) begin
                            bad_cnt_d = '0;
                        end else if (bad_inc == BAD_MAX) begin
                            // Loss of lock: load the acquisition weights in one step,
                            // with no ramp.
                            state_d    = ST_ACQUIRE;
                            weights_d  = acq_shadow_q;
                            locked_d   = 1'b0;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                            ramp_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= ST_IDLE;
            weights_q       <= '0;
            acq_shadow_q    <= '0;
            trk_shadow_q    <= '0;
            target_q        <= '0;
            good_cnt_q      <= '0;
            bad_cnt_q       <= '0;
            ramp_cnt_q      <= '0;
            cfg_load_prev_q <= 1'b0;
            cfg_ack_q       <= 1'b0;
            comb_reset_q    <= 1'b1;
            locked_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            weights_q       <= weights_d;
            acq_shadow_q    <= acq_shadow_d;
            trk_shadow_q    <= trk_shadow_d;
            target_q        <= target_d;
            good_cnt_q      <= good_cnt_d;
            bad_cnt_q       <= bad_cnt_d;
            ramp_cnt_q      <= ramp_cnt_d;
            cfg_load_prev_q <= cfg_load_prev_d;
            cfg_ack_q       <= cfg_ack_d;
            comb_reset_q    <= comb_reset_d;
            locked_q        <= locked_d;
        end
    end

    assign cfg_ack_o        = cfg_ack_q;
    assign weight_0_o       = weights_q[0*WEIGHT_W +: WEIGHT_W];
    assign weight_1_o       = weights_q[1*WEIGHT_W +: WEIGHT_W];
    assign weight_2_o       = weights_q[2*WEIGHT_W +: WEIGHT_W];
    assign weight_3_o       = weights_q[3*WEIGHT_W +: WEIGHT_W];
    assign combiner_reset_o = comb_reset_q;
    assign locked_o         = locked_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_error_weight_scheduler.sv
// Directed testbench for error_weight_scheduler with the default parameters.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
// Weight words are written as {w3,w2,w1,w0}, one hex digit per weight.
module tb_error_weight_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        enable_i;
    logic        sample_valid_i;
    logic [7:0]  error_comb_i;
    logic        cfg_load_i;
    logic [15:0] acq_weights_i;
    logic [15:0] trk_weights_i;
    logic        cfg_ack_o;
    logic [3:0]  weight_0_o, weight_1_o, weight_2_o, weight_3_o;
    logic        combiner_reset_o;
    logic        locked_o;
    logic [1:0]  state_o;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int ack_cnt;

    error_weight_scheduler dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .enable_i         (enable_i),
        .sample_valid_i   (sample_valid_i),
        .error_comb_i     (error_comb_i),
        .cfg_load_i       (cfg_load_i),
        .acq_weights_i    (acq_weights_i),
        .trk_weights_i    (trk_weights_i),
        .cfg_ack_o        (cfg_ack_o),
        .weight_0_o       (weight_0_o),
        .weight_1_o       (weight_1_o),
        .weight_2_o       (weight_2_o),
        .weight_3_o       (weight_3_o),
        .combiner_reset_o (combiner_reset_o),
        .locked_o         (locked_o),
        .state_o          (state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] wts();
        return {weight_3_o, weight_2_o, weight_1_o, weight_0_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample(input logic [7:0] e);
        sample_valid_i = 1'b1;
        error_comb_i   = e;
        tick();
        sample_valid_i = 1'b0;
    endtask

    initial begin
        reset_n_i      = 1'b0;
        enable_i       = 1'b0;
        sample_valid_i = 1'b0;
        error_comb_i   = 8'h00;
        cfg_load_i     = 1'b0;
        acq_weights_i  = 16'h0022;
        trk_weights_i  = 16'h1100;
        #12;
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_weights", 32'(wts()), 32'h0);
        check("rst_comb_reset", 32'(combiner_reset_o), 32'h1);
        check("rst_locked", 32'(locked_o), 32'h0);
        check("rst_ack", 32'(cfg_ack_o), 32'h0);
        reset_n_i = 1'b1;
        tick();

        // Config pulse while IDLE: the ack appears on the cycle after the edge only.
        cfg_load_i = 1'b1;
        tick();
        cfg_load_i = 1'b0;
        check("cfg_ack_pulse", 32'(cfg_ack_o), 32'h1);
        tick();
        check("cfg_ack_drop", 32'(cfg_ack_o), 32'h0);
        check("idle_hold", 32'(state_o), 32'h0);

        // Test 1: enable -> ACQUIRE with the acquisition weights.
        enable_i = 1'b1;
        tick();
        check("t1_state", 32'(state_o), 32'h1);
        check("t1_weights", 32'(wts()), 32'h0022);
        check("t1_comb_reset", 32'(combiner_reset_o), 32'h0);

        // Test 3: one bad sample in the middle restarts the good count.
        for (int i = 0; i < 15; i++) sample(8'd3);
        check("t3_15good", 32'(state_o), 32'h1);
        sample(8'(-20));
        for (int i = 0; i < 15; i++) sample(8'd3);
        check("t3_restart_15", 32'(state_o), 32'h1);
        sample(8'd3);
        check("t3_ramp_entry", 32'(state_o), 32'h2);
        check("t3_ramp_weights", 32'(wts()), 32'h0022);

        // Tests 2 and 5: ramp timing, with cfg_load_i held for 5 cycles carrying a new
        // tracking set that must not change this ramp's target.
        trk_weights_i = 16'h1111;
        cfg_load_i    = 1'b1;
        ack_cnt       = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (cfg_ack_o) ack_cnt++;
            if (c == 5) cfg_load_i = 1'b0;
            if (c == 7)  check("t2_before_step1", 32'(wts()), 32'h0022);
            if (c == 8)  check("t2_step1", 32'(wts()), 32'h1111);
            if (c == 15) check("t2_before_step2", 32'(wts()), 32'h1111);
            if (c == 16) begin
                check("t2_step2", 32'(wts()), 32'h1100);
                check("t2_not_locked_yet", 32'(locked_o), 32'h0);
            end
            if (c == 17) begin
                check("t2_track", 32'(state_o), 32'h3);
                check("t2_locked", 32'(locked_o), 32'h1);
                check("t5_target_kept", 32'(wts()), 32'h1100);
            end
        end
        check("t5_single_ack", 32'(ack_cnt), 32'd1);

        // Test 4: the unlock count restarts on a good sample, and -128 counts as bad.
        for (int i = 0; i < 3; i++) sample(8'd10);
        sample(8'd0);
        for (int i = 0; i < 3; i++) sample(8'h80);
        check("t4_still_track", 32'(state_o), 32'h3);
        sample(8'h80);
        check("t4_unlock_state", 32'(state_o), 32'h1);
        check("t4_unlock_weights", 32'(wts()), 32'h0022);
        check("t4_unlock_locked", 32'(locked_o), 32'h0);

        // Test 6: disable in the middle of a ramp, together with a sample strobe.
        for (int i = 0; i < 16; i++) sample(8'd2);
        check("t6_ramp", 32'(state_o), 32'h2);
        tick();
        tick();
        tick();
        enable_i       = 1'b0;
        sample_valid_i = 1'b1;
        error_comb_i   = 8'd3;
        tick();
        sample_valid_i = 1'b0;
        check("t6_idle", 32'(state_o), 32'h0);
        check("t6_weights", 32'(wts()), 32'h0);
        check("t6_comb_reset", 32'(combiner_reset_o), 32'h1);
        check("t6_locked", 32'(locked_o), 32'h0);

        // Equal weight sets: TRACK on the cycle after RAMP entry. |-4| sits exactly on
        // the threshold and counts as good, while 5 is just above it and counts as bad.
        acq_weights_i = 16'h1111;
        trk_weights_i = 16'h1111;
        cfg_load_i    = 1'b1;
        tick();
        cfg_load_i = 1'b0;
        check("eq_cfg_ack", 32'(cfg_ack_o), 32'h1);
        enable_i = 1'b1;
        tick();
        check("eq_acq_weights", 32'(wts()), 32'h1111);
        for (int i = 0; i < 16; i++) sample(8'(-4));
        check("eq_thresh_ramp", 32'(state_o), 32'h2);
        tick();
        check("eq_track", 32'(state_o), 32'h3);
        check("eq_locked", 32'(locked_o), 32'h1);
        for (int i = 0; i < 4; i++) sample(8'd5);
        check("eq_thresh_unlock", 32'(state_o), 32'h1);

        // Asynchronous reset applied between clock edges.
        for (int i = 0; i < 16; i++) sample(8'd0);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_rst_state", 32'(state_o), 32'h0);
        check("async_rst_weights", 32'(wts()), 32'h0);
        check("async_rst_comb_reset", 32'(combiner_reset_o), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
